tick_scheduler: RTL and testbench
=================================

TICK_SCHEDULER -- requirements
Module: tick_scheduler

Interface
REQ-001 SHALL have parameter WIDTH, default 28: width of divisor and counter.
REQ-002 SHALL have parameter DEFAULT_DIV, default 28'd100000000: divisor loaded at reset.
REQ-003 SHALL have parameter MIN_DIV, default 2: smallest accepted divisor.
REQ-004 SHALL have port Pulse  input  1  clock; all state updates on rising edge.
REQ-005 SHALL have port ResetN  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port Start  input  1  level, start/resume counting.
REQ-007 SHALL have port Stop  input  1  level, stop and clear counting.
REQ-008 SHALL have port Pause  input  1  level, freeze counting.
REQ-009 SHALL have port CfgValid  input  1  new divisor offered.
REQ-010 SHALL have port CfgDiv  input  WIDTH  offered divisor.
REQ-011 SHALL have port CfgReady  output  1  divisor can be accepted.
REQ-012 SHALL have port CfgErr  output  1  one-cycle pulse, offered divisor rejected.
REQ-013 SHALL have port Tick  output  1  one-cycle pulse per divided period.
REQ-014 SHALL have port View  output  1  divided square wave.
REQ-015 SHALL have port Running  output  1  high while in RUN.
REQ-016 SHALL have port TickCount  output  8  Tick count, wraps 255->0.

Function
REQ-017 SHALL implement states IDLE, RUN, PAUSE; command priority Stop > Pause > Start when asserted together.
REQ-018 IDLE: counter held at 0, View=0; Start -> RUN; Pause alone ignored.
REQ-019 RUN: counter increments by 1 per cycle; Pause -> PAUSE; Stop -> IDLE.
REQ-020 PAUSE: counter and View frozen, Tick=0; Start (no Stop/Pause) -> RUN, resuming from held count; Stop -> IDLE.
REQ-021 In RUN, when counter == div_active-1, counter SHALL wrap to 0 next cycle; Tick SHALL be 1 on that same next cycle only, and TickCount SHALL increment.
REQ-022 View SHALL be registered: in RUN, View at cycle n+1 = 1 iff counter value at cycle n < (div_active >> 1); odd divisors give the shorter half high.
REQ-023 Entry into IDLE (Stop) SHALL clear counter and View on the next edge; TickCount SHALL NOT clear.
REQ-024 Running SHALL be 1 exactly while state is RUN.
REQ-025 Config handshake: transfer occurs on a cycle with CfgValid=1 and CfgReady=1; CfgReady = NOT pend_valid, in all states.
REQ-026 Transferred CfgDiv < MIN_DIV SHALL be rejected: CfgErr=1 for one cycle next, no state change.
REQ-027 Accepted divisor in IDLE or PAUSE SHALL load div_active next cycle; in PAUSE the counter SHALL also clear to 0.
REQ-028 Accepted divisor in RUN SHALL go to a pending register (pend_valid=1, CfgReady drops next cycle); applied to div_active at the next wrap, clearing pend_valid on the same edge.
REQ-029 Stop while pend_valid=1 SHALL apply pending to div_active and clear pend_valid on the IDLE-entry edge.
REQ-030 Handshake and wrap on the same cycle in RUN: the value SHALL become pending; the old pending, if any, is applied at this wrap.
REQ-031 Counter compare SHALL use full WIDTH; no overflow with div_active <= 2^WIDTH-1.

Reset
REQ-032 ResetN=0 SHALL immediately force: state IDLE, counter 0, div_active=DEFAULT_DIV, pend_valid=0, Tick=0, View=0, Running=0, CfgErr=0, TickCount=0, CfgReady=1.
REQ-033 Reset asserted mid-RUN or mid-pending SHALL discard all progress and the pending divisor.

Verification (DEFAULT_DIV=4 for bench)
REQ-034 Reset release, Start for 1 cycle -> Running=1; Tick every 4 cycles; View pattern 1,1,0,0 repeating; TickCount 1,2,3...
REQ-035 In RUN, offer CfgDiv=6 -> CfgReady=0 until next wrap; following period is 6 cycles, View 1,1,1,0,0,0; CfgReady back to 1.
REQ-036 Offer CfgDiv=1 in IDLE -> CfgErr one-cycle pulse; div_active stays 4.
REQ-037 Pause at count 2 for 10 cycles, then Start -> no Tick during pause; next Tick 2 cycles after resume.
REQ-038 Stop+Pause+Start same cycle in RUN -> IDLE, counter 0, View 0, Running 0.
REQ-039 ResetN low mid-RUN with pending divisor -> all outputs reset values asynchronously; after restart period is 4.

Source files
------------

// File: rtl/tick_scheduler.sv
// tick_scheduler: programmable divider producing Tick pulses and a View square wave,
// with start/stop/pause control and a ready/valid divisor update channel.
module tick_scheduler #(
  parameter int WIDTH = 28,
  parameter logic [WIDTH-1:0] DEFAULT_DIV = 28'd100000000,
  parameter logic [WIDTH-1:0] MIN_DIV = WIDTH'(2)
) (
  input  logic             Pulse,
  input  logic             ResetN,
  input  logic             Start,
  input  logic             Stop,
  input  logic             Pause,
  input  logic             CfgValid,
  input  logic [WIDTH-1:0] CfgDiv,
  output logic             CfgReady,
  output logic             CfgErr,
  output logic             Tick,
  output logic             View,
  output logic             Running,
  output logic [7:0]       TickCount
);
  typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;
  state_t state, state_nxt;
  logic [WIDTH-1:0] counter, div_active, pend_div;
  logic pend_valid, advance, wrap, xfer, bad, good;
  always_ff @(posedge Pulse or negedge ResetN)
    if (!ResetN) state <= IDLE;
    else state <= state_nxt;
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    state_nxt = (Start && !Stop && !Pause) ? RUN : IDLE;
      RUN:     state_nxt = Stop ? IDLE : Pause ? PAUSE : RUN;
      default: state_nxt = Stop ? IDLE : Pause ? PAUSE : Start ? RUN : PAUSE;
    endcase
  end
  assign advance  = state == RUN && !Stop && !Pause;
  assign wrap     = advance && counter == div_active - 1'b1;
  assign xfer     = CfgValid && CfgReady;
  assign bad      = xfer && CfgDiv < MIN_DIV;
  assign good     = xfer && !bad;
  assign CfgReady = !pend_valid;
  assign Running  = state == RUN;
  always_ff @(posedge Pulse or negedge ResetN)
    if (!ResetN) begin
      counter    <= '0;
      div_active <= DEFAULT_DIV;
      pend_div   <= '0;
      pend_valid <= 1'b0;
      Tick       <= 1'b0;
      View       <= 1'b0;
      CfgErr     <= 1'b0;
      TickCount  <= '0;
    end else begin
      CfgErr    <= bad;
      Tick      <= wrap;
      TickCount <= TickCount + {7'd0, wrap};
      if (Stop) begin
        counter <= '0;
        View    <= 1'b0;
      end else if (advance) begin
        counter <= wrap ? '0 : counter + 1'b1;
        View    <= counter < (div_active >> 1);
      end else if (state == PAUSE && good) counter <= '0;
      // A divisor accepted mid-run waits for the wrap unless the run is ending now
      if (good) begin
        if (state == RUN && !Stop) begin
          pend_valid <= 1'b1;
          pend_div   <= CfgDiv;
        end else div_active <= CfgDiv;
      end else if (pend_valid && (Stop || wrap)) begin
        div_active <= pend_div;
        pend_valid <= 1'b0;
      end
    end
endmodule

// File: tb/tb_tick_scheduler.sv
// tb_tick_scheduler: randomized scoreboard bench for tick_scheduler against a
// behavioural model of the divider's modes, period and pending-divisor rules.
module tb_tick_scheduler;
  logic Pulse = 1'b0, ResetN = 1'b0, Start = 1'b0, Stop = 1'b0, Pause = 1'b0, CfgValid = 1'b0;
  logic [27:0] CfgDiv = '0;
  logic CfgReady, CfgErr, Tick, View, Running;
  logic [7:0] TickCount;

  tick_scheduler #(.WIDTH(28), .DEFAULT_DIV(28'd4), .MIN_DIV(28'd2)) dut (
    .Pulse(Pulse), .ResetN(ResetN), .Start(Start), .Stop(Stop), .Pause(Pause),
    .CfgValid(CfgValid), .CfgDiv(CfgDiv), .CfgReady(CfgReady), .CfgErr(CfgErr),
    .Tick(Tick), .View(View), .Running(Running), .TickCount(TickCount)
  );

  always #5 Pulse = ~Pulse;

  typedef struct {
    logic tick, view, running, err, ready;
    logic [7:0] tc;
  } exp_t;
  exp_t q[$];
  int checks = 0, errors = 0;

  // model: mode 0=idle 1=run 2=pause; cnt is position within current period
  int mode, cnt, div, tc;
  int pend[$];
  bit m_tick, m_view, m_err;

  function automatic exp_t snap();
    exp_t e;
    e.tick = m_tick; e.view = m_view; e.running = (mode == 1); e.err = m_err;
    e.ready = (pend.size() == 0); e.tc = 8'(tc);
    return e;
  endfunction

  function automatic void model(bit st, bit sp, bit pa, bit cv, int cd);
    bit acc = cv && pend.size() == 0;
    bit ok = acc && cd >= 2;
    m_tick = 0;
    m_err = acc && cd < 2;
    if (mode == 0) begin
      if (ok) div = cd;
      if (st && !sp && !pa) mode = 1;
    end else if (mode == 1) begin
      if (sp) begin
        if (pend.size() > 0) div = pend.pop_front();
        if (ok) div = cd;
        cnt = 0; m_view = 0; mode = 0;
      end else if (pa) begin
        if (ok) pend.push_back(cd);
        mode = 2;
      end else begin
        m_view = cnt < div / 2;
        if (cnt == div - 1) begin
          cnt = 0; m_tick = 1; tc = (tc + 1) % 256;
          if (pend.size() > 0) div = pend.pop_front();
        end else cnt++;
        if (ok) pend.push_back(cd);
      end
    end else begin
      if (ok) begin div = cd; cnt = 0; end
      if (sp) begin
        if (pend.size() > 0) div = pend.pop_front();
        cnt = 0; m_view = 0; mode = 0;
      end else if (!pa && st) mode = 1;
    end
  endfunction

  task automatic step(bit st, bit sp, bit pa, bit cv, int cd);
    exp_t e;
    Start = st; Stop = sp; Pause = pa; CfgValid = cv; CfgDiv = 28'(cd);
    model(st, sp, pa, cv, cd);
    e = snap();
    @(posedge Pulse);
    q.push_back(e);
    #1;
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0);
  endtask

  task automatic chk(string name, logic [7:0] got, logic [7:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h t=%0t", name, got, want, $time);
    end
  endtask

  task automatic do_reset();
    @(negedge Pulse);
    #1;
    Start = 0; Stop = 0; Pause = 0; CfgValid = 0;
    ResetN = 0;
    #1;
    chk("rst_tick", {7'd0, Tick}, 8'd0);
    chk("rst_view", {7'd0, View}, 8'd0);
    chk("rst_running", {7'd0, Running}, 8'd0);
    chk("rst_err", {7'd0, CfgErr}, 8'd0);
    chk("rst_ready", {7'd0, CfgReady}, 8'd1);
    chk("rst_tickcount", TickCount, 8'd0);
    mode = 0; cnt = 0; div = 4; tc = 0; pend.delete();
    m_tick = 0; m_view = 0; m_err = 0;
    @(posedge Pulse);
    #1;
    ResetN = 1;
  endtask

  always @(negedge Pulse) begin : monitor
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      checks++;
      if ({Tick, View, Running, CfgErr, CfgReady, TickCount} !==
          {e.tick, e.view, e.running, e.err, e.ready, e.tc}) begin
        errors++;
        $display("FAIL outputs t=%0t got tick=%b view=%b run=%b err=%b rdy=%b cnt=%0d want tick=%b view=%b run=%b err=%b rdy=%b cnt=%0d",
                 $time, Tick, View, Running, CfgErr, CfgReady, TickCount,
                 e.tick, e.view, e.running, e.err, e.ready, e.tc);
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1);
  end

  initial begin
    do_reset();
    step(1, 0, 0, 0, 0);
    idle(13);
    step(0, 0, 0, 1, 6);
    idle(18);
    do_reset();
    step(0, 0, 0, 1, 1);
    idle(3);
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < 20 && cnt != 2; i++) step(0, 0, 0, 0, 0);
    for (int i = 0; i < 10; i++) step(0, 0, 1, 0, 0);
    step(1, 0, 0, 0, 0);
    idle(6);
    step(1, 1, 1, 0, 0);
    idle(3);
    step(1, 0, 0, 0, 0);
    idle(2);
    step(0, 0, 0, 1, 7);
    idle(1);
    do_reset();
    step(1, 0, 0, 0, 0);
    idle(10);
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 499) == 0) do_reset();
      else step($urandom_range(0, 3) == 0, $urandom_range(0, 29) == 0,
                $urandom_range(0, 9) == 0, $urandom_range(0, 7) == 0,
                int'($urandom_range(0, 9)));
    end
    step(0, 0, 0, 0, 0);
    @(negedge Pulse);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
